eth_rx_port_arbiter: RTL and testbench
======================================

Name: eth_rx_port_arbiter

Overview:
Frame-granular round-robin arbiter that shares one ethernet_frame_parser between N_PORTS AXI-Stream ingress ports.
- Grants one port at a time and holds the grant until the frame's tlast beat is accepted downstream. Frames are never interleaved.
- Tags every output beat with the source port index.
- Keeps per-port frame counters for status readout.
- Sits between the MAC receive ports and the parser's s_axis interface.

Parameters:
DATA_WIDTH, 64, AXI-Stream data width in bits; must be a multiple of 8.
N_PORTS, 4, number of ingress ports; legal range 2..16.
PORT_W, $clog2(N_PORTS), width of the port index (derived; do not override).
CNT_W, 16, width of each per-port frame counter.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
s_axis_tdata  in  N_PORTS*DATA_WIDTH  ingress data; port p uses bits [p*DATA_WIDTH +: DATA_WIDTH]
s_axis_tvalid  in  N_PORTS  ingress valid, one bit per port
s_axis_tlast  in  N_PORTS  ingress last, one bit per port
s_axis_tready  out  N_PORTS  ingress ready, one bit per port
m_axis_tdata  out  DATA_WIDTH  data to the parser
m_axis_tvalid  out  1  valid to the parser
m_axis_tlast  out  1  last to the parser
m_axis_tready  in  1  ready from the parser
m_axis_tid  out  PORT_W  index of the port currently granted
busy  out  1  high while a frame is in flight (state PASS)
frame_cnt  out  N_PORTS*CNT_W  completed frames per port; port p uses bits [p*CNT_W +: CNT_W]

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - state = IDLE; grant = 0.
  - last_grant = N_PORTS-1, so port 0 has first priority after reset.
  - All frame_cnt = 0; busy = 0.
  - s_axis_tready = 0; m_axis_tvalid = 0; m_axis_tid = 0.
- FSM states: IDLE and PASS.
- IDLE:
  - All s_axis_tready are 0 and m_axis_tvalid is 0.
  - If any s_axis_tvalid bit is set, pick the first requesting port scanning upward (with wrap) from last_grant+1.
  - Register the pick into grant and go to PASS on the next edge.
  - If no port requests, stay in IDLE.
- PASS (combinational mux from the registered grant):
  - m_axis_tdata/tvalid/tlast = port[grant] signals.
  - s_axis_tready[grant] = m_axis_tready; all other ready bits are 0.
  - m_axis_tid = grant; busy = 1.
- End of frame: a transfer with m_axis_tvalid & m_axis_tready & m_axis_tlast means:
  - last_grant <= grant;
  - frame_cnt[grant] increments (wraps modulo 2^CNT_W);
  - next state = IDLE.
- Latency: one arbitration cycle (IDLE) between consecutive frames. The data path adds no register stage, so there is zero beat latency in PASS.
- Handshake rules:
  - A granted port that drops tvalid mid-frame keeps the grant. Bubbles pass through as m_axis_tvalid = 0.
  - Downstream backpressure (m_axis_tready = 0) stalls only the granted port.
  - Non-granted ports see tready = 0 and must hold their data (AXI-S rules).
- Fairness: after port k completes a frame, port k is lowest priority at the next arbitration. With all ports continuously requesting, the grant sequence is 0,1,2,...,N-1,0,...
- Single-beat frame (tvalid & tlast on the first beat): legal. Spends one cycle in PASS, then returns to IDLE.
- A request that arrives in the same cycle as end-of-frame is seen at the next IDLE cycle.
- A requester that deasserts tvalid while in IDLE before being granted is simply not chosen. No state is kept per requester.
- Reset asserted mid-frame: return to IDLE immediately and clear counters. The partial frame is lost; upstream is responsible for resynchronising.
- Counter wrap: frame_cnt = 0xFFFF plus one more frame gives 0x0000, with no flag.

Decomposition:
- Add to eth_parser_pkg:
  - ARB_IDLE / ARB_PASS enum typedef arb_state_t;
  - localparam ETH_ARB_MAX_PORTS = 16.
- One combinational sub-module, eth_rr_pick:
  - Parameter N.
  - Inputs: req[N], last[$clog2(N)].
  - Outputs: pick, any.
  - Implemented as a rotate / priority-encode / unrotate.

Test Plan:
1. Reset, then port 2 sends one 3-beat frame (data 0x1..0x3) with m_axis_tready = 1 -> beats appear unchanged with m_axis_tid = 2, tlast on beat 3. frame_cnt[2] = 1, others 0. busy low after the frame.
2. All 4 ports request continuously with 2-beat frames -> grant order 0,1,2,3,0,1. Exactly one IDLE cycle between frames. No interleaving of beats.
3. Port 1 is mid-frame when m_axis_tready is held low for 5 cycles while port 3 requests -> port 1 data is held stable. s_axis_tready[3] stays 0 throughout. Port 3 is granted only after port 1's tlast.
4. Port 0 is mid-frame and drops tvalid for 3 cycles -> m_axis_tvalid = 0 for those cycles, grant stays 0, frame completes intact.
5. Single-beat frames on ports 0 and 1 back to back -> PASS lasts 1 cycle each, m_axis_tid goes 0 then 1. frame_cnt = {0,0,1,1}.
6. rst pulsed during beat 2 of a 4-beat frame on port 3 -> next cycle state is IDLE, all tready = 0, all frame_cnt = 0. Next arbitration starts from port 0.

Source files
------------

// File: rtl/eth_rx_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// eth_rx_port_arbiter_pkg
// Shared types and constants for the ingress-port arbiter that sits in front
// of the ethernet frame parser.
//   arb_state_t        : arbiter FSM state (IDLE = arbitrating, PASS = frame
//                        in flight from the granted port)
//   ETH_ARB_MAX_PORTS  : largest supported number of ingress ports
// -----------------------------------------------------------------------------
package eth_rx_port_arbiter_pkg;

   localparam int ETH_ARB_MAX_PORTS = 16;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_PASS = 1'b1
   } arb_state_t;

endpackage : eth_rx_port_arbiter_pkg

// File: rtl/eth_rx_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// eth_rx_port_arbiter_if
// AXI-Stream bundle carrying N parallel lanes of DW-bit data. The ingress side
// of the arbiter uses N = N_PORTS (one lane per MAC port); the egress side to
// the parser uses N = 1 and carries the source-port tag on tid.
//   tdata  [N*DW] : lane p uses bits [p*DW +: DW]
//   tvalid [N]    : per-lane valid
//   tlast  [N]    : per-lane end of frame
//   tready [N]    : per-lane ready (driven by the sink)
//   tid    [TID_W]: source tag (meaningful on the egress side only)
// Modports: master = stream source, slave = stream sink.
// -----------------------------------------------------------------------------
interface eth_rx_port_arbiter_if #(
   parameter int DW    = 64,
   parameter int N     = 1,
   parameter int TID_W = 1
);

   logic [N*DW-1:0]  tdata;
   logic [N-1:0]     tvalid;
   logic [N-1:0]     tlast;
   logic [N-1:0]     tready;
   logic [TID_W-1:0] tid;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      output tid,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      input  tid,
      output tready
   );

endinterface : eth_rx_port_arbiter_if

// File: rtl/eth_rx_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// eth_rr_pick
// Combinational round-robin selector. Returns the first set bit of req found
// scanning upward from last+1 with wrap-around, so the port named by last has
// the lowest priority.
//   req  [N]      : request vector
//   last [LW]     : index of the most recently served requester
//   pick [LW]     : selected index (only meaningful when any = 1)
//   any           : at least one request present
// -----------------------------------------------------------------------------
module eth_rr_pick #(
   parameter int N  = 4,
   parameter int LW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [LW-1:0] last,
   output logic [LW-1:0] pick,
   output logic          any
);

   logic [N-1:0] rot;
   int unsigned  idx;
   logic         found;

   // Rotate so that bit 0 is port last+1, take the lowest set bit, then map
   // the rotated position back to a real port index.
   always_comb begin
      rot   = '0;
      idx   = 0;
      found = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         rot[i] = req[(int'(last) + 1 + i) % N];
      end
      for (int unsigned i = 0; i < N; i++) begin
         if (rot[i] && !found) begin
            found = 1'b1;
            idx   = i;
         end
      end
      pick = LW'((int'(last) + 1 + idx) % N);
      any  = |req;
   end

endmodule : eth_rr_pick

// File: rtl/eth_rx_port_arbiter.sv
// -----------------------------------------------------------------------------
// eth_rx_port_arbiter
// Frame-granular round-robin arbiter sharing one frame parser between N_PORTS
// AXI-Stream ingress ports. A grant is held until the granted port's tlast
// beat is accepted downstream, so frames are never interleaved. Every output
// beat carries the source port index on m_axis.tid.
//   clk        : system clock
//   rst        : synchronous, active-high reset
//   s_axis     : ingress bundle, N_PORTS lanes (sink side)
//   m_axis     : egress bundle to the parser, one lane, tid = granted port
//   busy       : high while a frame is in flight
//   frame_cnt  : completed frames per port, port p at [p*CNT_W +: CNT_W],
//                wrapping modulo 2^CNT_W
// -----------------------------------------------------------------------------
module eth_rx_port_arbiter
   import eth_rx_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int N_PORTS    = 4,
   parameter int PORT_W     = $clog2(N_PORTS),
   parameter int CNT_W      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   eth_rx_port_arbiter_if.slave       s_axis,
   eth_rx_port_arbiter_if.master      m_axis,
   output logic                       busy,
   output logic [N_PORTS*CNT_W-1:0]   frame_cnt
);

   arb_state_t        state_q, state_d;
   logic [PORT_W-1:0] grant_q, grant_d;
   logic [PORT_W-1:0] last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  cnt_q [N_PORTS];

   logic [PORT_W-1:0] rr_pick;
   logic              rr_any;
   logic              eof;

   eth_rr_pick #(
      .N  (N_PORTS),
      .LW (PORT_W)
   ) u_pick (
      .req  (s_axis.tvalid),
      .last (last_grant_q),
      .pick (rr_pick),
      .any  (rr_any)
   );

   // Next state and the pass-through data path. The data path has no
   // register stage: in PASS the granted lane is muxed straight to the parser.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_grant_d  = last_grant_q;
      eof           = 1'b0;
      busy          = 1'b0;
      s_axis.tready = '0;
      m_axis.tvalid = 1'b0;
      m_axis.tlast  = 1'b0;
      m_axis.tid    = '0;
      m_axis.tdata  = s_axis.tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];

      unique case (state_q)
         ARB_IDLE: begin
            if (rr_any) begin
               grant_d = rr_pick;
               state_d = ARB_PASS;
            end
         end
         ARB_PASS: begin
            busy                   = 1'b1;
            m_axis.tid             = grant_q;
            m_axis.tvalid          = s_axis.tvalid[grant_q];
            m_axis.tlast           = s_axis.tlast[grant_q];
            s_axis.tready[grant_q] = m_axis.tready;
            if (s_axis.tvalid[grant_q] && m_axis.tready && s_axis.tlast[grant_q]) begin
               eof          = 1'b1;
               last_grant_d = grant_q;
               state_d      = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         grant_q      <= '0;
         last_grant_q <= PORT_W'(N_PORTS - 1);
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned p = 0; p < N_PORTS; p++) begin
            cnt_q[p] <= '0;
         end
      end else if (eof) begin
         cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
      end
   end

   always_comb begin
      frame_cnt = '0;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
         frame_cnt[p*CNT_W +: CNT_W] = cnt_q[p];
      end
   end

endmodule : eth_rx_port_arbiter

// File: tb/tb_eth_rx_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_eth_rx_port_arbiter
// Randomized scoreboard bench for eth_rx_port_arbiter. Frames are queued per
// port; a reference model serves the pending frames in round-robin order and
// pushes the expected egress beats into a queue that a separate monitor pops.
// -----------------------------------------------------------------------------
module tb_eth_rx_port_arbiter;

   localparam int NP = 4;
   localparam int DW = 64;
   localparam int PW = 2;
   localparam int CW = 4;

   typedef struct {
      logic [DW-1:0] data;
      bit            last;
      int            tid;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   logic [NP*CW-1:0] frame_cnt;

   eth_rx_port_arbiter_if #(.DW(DW), .N(NP), .TID_W(PW)) s_if ();
   eth_rx_port_arbiter_if #(.DW(DW), .N(1),  .TID_W(PW)) m_if ();

   eth_rx_port_arbiter #(
      .DATA_WIDTH (DW),
      .N_PORTS    (NP),
      .CNT_W      (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .s_axis    (s_if),
      .m_axis    (m_if),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   always #5 clk = ~clk;

   beat_t   drv_q [NP][$];
   beat_t   mdl_q [NP][$];
   beat_t   exp_q [$];
   bit      mid   [NP];
   logic [NP-1:0] hs = '0;
   int      model_last = NP - 1;
   int      model_cnt [NP];
   int      rdy_pct = 100;
   int      bub_pct = 0;
   int      checks = 0;
   int      fails  = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add_frame(input int p, input int len, input bit seq);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = seq ? DW'(i + 1) : {$urandom, $urandom};
         b.last = (i == len - 1);
         b.tid  = p;
         drv_q[p].push_back(b);
         mdl_q[p].push_back(b);
      end
   endtask

   // Reference: serve whole pending frames round-robin, starting after the
   // port that completed the previous frame.
   task automatic build_expected();
      bit done;
      beat_t b;
      forever begin
         done = 1'b1;
         for (int k = 1; k <= NP; k++) begin
            int p;
            p = (model_last + k) % NP;
            if (mdl_q[p].size() > 0) begin
               do begin
                  b = mdl_q[p].pop_front();
                  exp_q.push_back(b);
               end while (!b.last);
               model_cnt[p] = (model_cnt[p] + 1) % (1 << CW);
               model_last   = p;
               done         = 1'b0;
               break;
            end
         end
         if (done) break;
      end
   endtask

   task automatic run_phase(input int rp, input int bp);
      int cyc;
      rdy_pct = rp;
      bub_pct = bp;
      build_expected();
      cyc = 0;
      while ((exp_q.size() != 0 || busy) && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 3000) begin
         fails++;
         $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
      end
      repeat (2) @(negedge clk);
      chk("busy_after_drain", DW'(busy), '0);
      for (int p = 0; p < NP; p++) begin
         chk($sformatf("frame_cnt[%0d]", p), DW'(frame_cnt[p*CW +: CW]), DW'(model_cnt[p]));
      end
   endtask

   // Driver: update ingress lanes and downstream ready just after each edge.
   initial begin
      s_if.tvalid = '0;
      s_if.tlast  = '0;
      s_if.tdata  = '0;
      s_if.tid    = '0;
      m_if.tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         for (int p = 0; p < NP; p++) begin
            if (hs[p] && drv_q[p].size() > 0) begin
               mid[p] = !drv_q[p][0].last;
               void'(drv_q[p].pop_front());
            end
         end
         for (int p = 0; p < NP; p++) begin
            if (drv_q[p].size() > 0) begin
               s_if.tvalid[p]          = !(mid[p] && ($urandom_range(0, 99) < bub_pct));
               s_if.tlast[p]           = drv_q[p][0].last;
               s_if.tdata[p*DW +: DW]  = drv_q[p][0].data;
            end else begin
               s_if.tvalid[p]          = 1'b0;
               s_if.tlast[p]           = 1'b0;
               s_if.tdata[p*DW +: DW]  = '0;
            end
         end
         m_if.tready = ($urandom_range(0, 99) < rdy_pct);
      end
   end

   // Monitor: compare egress beats and per-cycle handshake rules mid-cycle.
   initial begin
      bit prev_eof = 1'b0;
      bit prev_idle_req = 1'b0;
      beat_t e;
      logic [NP-1:0] exp_rdy;
      forever begin
         @(negedge clk);
         if (rst) begin
            hs            = '0;
            prev_eof      = 1'b0;
            prev_idle_req = 1'b0;
         end else begin
            hs = s_if.tvalid & s_if.tready;
            if (busy && exp_q.size() > 0) begin
               exp_rdy = m_if.tready ? (NP'(1) << exp_q[0].tid) : '0;
               chk("s_tready_grant", DW'(s_if.tready), DW'(exp_rdy));
            end else if (!busy) begin
               chk("idle_outputs", DW'({s_if.tready, m_if.tvalid[0]}), '0);
            end
            if (m_if.tvalid[0] && m_if.tready[0]) begin
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL unexpected_beat: got data %0h tid %0d expected none", m_if.tdata, m_if.tid);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_data", m_if.tdata, e.data);
                  chk("beat_last_tid", DW'({m_if.tlast[0], m_if.tid}), DW'({e.last, PW'(e.tid)}));
               end
            end
            if (prev_eof)      chk("one_idle_gap", DW'(busy), '0);
            if (prev_idle_req) chk("arb_one_cycle", DW'(busy), DW'(1));
            prev_eof      = m_if.tvalid[0] && m_if.tready[0] && m_if.tlast[0];
            prev_idle_req = !busy && (s_if.tvalid != '0);
         end
      end
   end

   initial begin
      int cyc;
      for (int p = 0; p < NP; p++) begin
         model_cnt[p] = 0;
         mid[p]       = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_s_tready", DW'(s_if.tready), '0);
      chk("rst_m_tvalid", DW'(m_if.tvalid), '0);
      chk("rst_m_tid", DW'(m_if.tid), '0);
      chk("rst_busy", DW'(busy), '0);
      chk("rst_frame_cnt", DW'(frame_cnt), '0);
      rst = 1'b0;

      // Single 3-beat frame on port 2, data 1..3.
      add_frame(2, 3, 1'b1);
      run_phase(100, 0);

      // All ports, two 2-beat frames each.
      for (int p = 0; p < NP; p++) begin
         add_frame(p, 2, 1'b0);
         add_frame(p, 2, 1'b0);
      end
      run_phase(100, 0);

      // Long frame under heavy backpressure with a competing requester.
      add_frame(1, 6, 1'b0);
      add_frame(3, 2, 1'b0);
      run_phase(30, 0);

      // Mid-frame bubbles.
      add_frame(0, 5, 1'b0);
      run_phase(100, 60);

      // Back-to-back single-beat frames.
      add_frame(0, 1, 1'b0);
      add_frame(1, 1, 1'b0);
      run_phase(100, 0);

      // Random traffic; per-port totals exceed 2^CW so counters wrap.
      for (int ph = 0; ph < 25; ph++) begin
         for (int p = 0; p < NP; p++) begin
            int nf;
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) add_frame(p, $urandom_range(1, 5), 1'b0);
         end
         run_phase($urandom_range(30, 100), 25);
      end

      // Reset in the middle of a 4-beat frame on port 3.
      add_frame(3, 4, 1'b0);
      rdy_pct = 100;
      bub_pct = 0;
      build_expected();
      cyc = 0;
      while (exp_q.size() > 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 200) begin
         fails++;
         $display("FAIL mid_frame_start: got %0d beats left expected 3", exp_q.size());
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      for (int p = 0; p < NP; p++) begin
         drv_q[p].delete();
         mdl_q[p].delete();
         mid[p]       = 1'b0;
         model_cnt[p] = 0;
      end
      exp_q.delete();
      model_last = NP - 1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_s_tready", DW'(s_if.tready), '0);
      chk("midrst_m_tvalid", DW'(m_if.tvalid), '0);
      chk("midrst_busy", DW'(busy), '0);
      chk("midrst_frame_cnt", DW'(frame_cnt), '0);
      rst = 1'b0;

      // Arbitration restarts from port 0.
      add_frame(3, 2, 1'b0);
      add_frame(1, 2, 1'b0);
      add_frame(0, 2, 1'b0);
      run_phase(100, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule : tb_eth_rx_port_arbiter
